tff_count_ctrl: RTL and testbench

//  Sequencer for the T-flip-flop binary counter datapath (sync-enable chain).

---
 rtl/tff_count_ctrl_if.sv | 30 +++
 rtl/tff_count_ctrl.sv | 91 +++++++++
 tb/tb_tff_count_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// Control/readback bundle between the T-flip-flop counter sequencer and its user.
// The master side supplies commands and the counter readback. The slave side is
// the sequencer, which returns the counter controls and status.
interface tff_count_ctrl_if #(
  parameter int W    = 4,
  parameter int LAPW = 8
);
  logic            start;
  logic            stop;
  logic            pause;
  logic            mode;
  logic [W-1:0]    tc;
  logic [W-1:0]    cnt_q;
  logic            cnt_en;
  logic            cnt_clr;
  logic            busy;
  logic            paused;
  logic            done;
  logic [LAPW-1:0] laps;

  modport master (
    output start, stop, pause, mode, tc, cnt_q,
    input  cnt_en, cnt_clr, busy, paused, done, laps
  );

  modport slave (
    input  start, stop, pause, mode, tc, cnt_q,
    output cnt_en, cnt_clr, busy, paused, done, laps
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer for a T-flip-flop binary counter. It clears the counter, enables it
// until the readback equals the latched terminal count, and then reports a
// completed period. It supports one-shot and auto-reload runs, pause/resume,
// abort, and a saturating lap count.
module tff_count_ctrl #(
  parameter int W    = 4,
  parameter int LAPW = 8
) (
  input  logic           ck,
  input  logic           rs,
  tff_count_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    tc_reg, tc_next;
  logic            mode_reg, mode_next;
  logic [LAPW-1:0] laps_reg, laps_next;
  logic            at_tc;

  // The counter readback has reached the latched terminal count.
  assign at_tc = (bus.cnt_q == tc_reg);

  // State and run-parameter registers. Reset does not touch the counter itself.
  always_ff @(posedge ck) begin
    if (rs) begin
      state_reg <= IDLE;
      tc_reg    <= '0;
      mode_reg  <= 1'b0;
      laps_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tc_reg    <= tc_next;
      mode_reg  <= mode_next;
      laps_reg  <= laps_next;
    end
  end

  // Next-state logic. tc and mode are latched only on an accepted start.
  always_comb begin
    state_next = state_reg;
    tc_next    = tc_reg;
    mode_next  = mode_reg;
    laps_next  = laps_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          tc_next    = bus.tc;
          mode_next  = bus.mode;
          laps_next  = '0;
          state_next = CLR;
        end
      end
      CLR: state_next = RUN;
      RUN: begin
        if (bus.stop)       state_next = IDLE;
        else if (bus.pause) state_next = HOLD;
        else if (at_tc)     state_next = DONE;
      end
      HOLD: begin
        if (bus.stop)        state_next = IDLE;
        else if (!bus.pause) state_next = RUN;
      end
      DONE: begin
        // The lap counter sticks at all-ones rather than wrapping.
        if (laps_reg != {LAPW{1'b1}}) laps_next = laps_reg + 1'b1;
        if (bus.stop)      state_next = IDLE;
        else if (mode_reg) state_next = CLR;
        else               state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The enable is combinational, so pause and stop freeze the counter in the
  // same cycle they are seen. The enable also drops as soon as the readback hits tc.
  assign bus.cnt_en  = (state_reg == RUN) & ~bus.stop & ~bus.pause & ~at_tc;
  assign bus.cnt_clr = (state_reg == CLR);
  assign bus.busy    = (state_reg != IDLE);
  assign bus.paused  = (state_reg == HOLD);
  assign bus.done    = (state_reg == DONE);
  assign bus.laps    = laps_reg;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl. A behavioural T-flip-flop counter closes the loop.
// Cycle n means the cycle after the n-th edge, where start is sampled at edge 0.
module tb_tff_count_ctrl;

  logic ck = 1'b0;
  logic rs = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  tff_count_ctrl_if #(.W(4), .LAPW(8)) bus_a ();
  tff_count_ctrl_if #(.W(4), .LAPW(2)) bus_b ();

  tff_count_ctrl #(.W(4), .LAPW(8)) dut_a (.ck(ck), .rs(rs), .bus(bus_a));
  tff_count_ctrl #(.W(4), .LAPW(2)) dut_b (.ck(ck), .rs(rs), .bus(bus_b));

  always #5 ck = ~ck;

  // Counter models: synchronous clear wins over the count enable.
  logic [3:0] cnt_a = '0;
  logic [3:0] cnt_b = '0;
  always @(posedge ck) begin
    if (bus_a.cnt_clr)     cnt_a <= '0;
    else if (bus_a.cnt_en) cnt_a <= cnt_a + 1'b1;
    if (bus_b.cnt_clr)     cnt_b <= '0;
    else if (bus_b.cnt_en) cnt_b <= cnt_b + 1'b1;
  end
  assign bus_a.cnt_q = cnt_a;
  assign bus_b.cnt_q = cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Pulses start for edge 0. The task returns in cycle 1.
  task automatic start_a(input logic [3:0] t, input logic m);
    bus_a.tc    = t;
    bus_a.mode  = m;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  // Scans cycles from c0 until done is seen, tallying enables and clears on the way.
  // The task returns in the done cycle. dc is -1 if the bound expires.
  task automatic run_until_done(input int c0, input int limit,
                                output int dc, output int en_n, output int clr_n);
    int  c;
    bit  found;
    c = c0; found = 0; en_n = 0; clr_n = 0; dc = -1;
    for (int k = 0; k < limit && !found; k++) begin
      if (bus_a.cnt_en)  en_n++;
      if (bus_a.cnt_clr) clr_n++;
      if (bus_a.done) begin
        dc = c;
        found = 1;
      end else begin
        step();
        c++;
      end
    end
  endtask

  initial begin
    int dc, en_n, clr_n, c;
    logic [1:0] lap_exp [5];
    bit found;

    {bus_a.start, bus_a.stop, bus_a.pause, bus_a.mode} = '0;
    {bus_b.start, bus_b.stop, bus_b.pause, bus_b.mode} = '0;
    bus_a.tc = '0;
    bus_b.tc = '0;

    // Reset state
    step(); step();
    rs = 1'b0;
    chk("rst_busy",  bus_a.busy,    0);
    chk("rst_clr",   bus_a.cnt_clr, 0);
    chk("rst_laps",  bus_a.laps,    0);
    $display("reset released: busy=%0d laps=%0d", bus_a.busy, bus_a.laps);

    // T1: reset in the middle of RUN
    start_a(4'd9, 1'b0);
    step(); step(); step(); step();               // cycle 5, cnt_q = 3
    chk("t1_cntq_pre", cnt_a, 3);
    rs = 1'b1;
    step(); step();
    chk("t1_busy",  bus_a.busy,    0);
    chk("t1_en",    bus_a.cnt_en,  0);
    chk("t1_clr",   bus_a.cnt_clr, 0);
    chk("t1_done",  bus_a.done,    0);
    chk("t1_laps",  bus_a.laps,    0);
    chk("t1_cntq",  cnt_a,         4);             // counter is not cleared by reset
    rs = 1'b0;
    step();
    $display("T1 reset mid-run: busy=%0d cnt_q=%0d", bus_a.busy, cnt_a);

    // T2: one-shot with tc=5
    start_a(4'd5, 1'b0);
    run_until_done(1, 40, dc, en_n, clr_n);
    chk("t2_done_cyc", dc, 8);
    chk("t2_en_cnt",   en_n, 5);
    chk("t2_clr_cnt",  clr_n, 1);
    chk("t2_cntq",     cnt_a, 5);
    step();
    chk("t2_laps",     bus_a.laps, 1);
    chk("t2_busy",     bus_a.busy, 0);
    chk("t2_done_off", bus_a.done, 0);
    $display("T2 one-shot tc=5: done_cycle=%0d en=%0d laps=%0d", dc, en_n, bus_a.laps);

    // T3: auto-reload with tc=3. The period is 6 cycles.
    start_a(4'd3, 1'b1);
    c = 1;
    for (int p = 0; p < 4; p++) begin
      run_until_done(c, 40, dc, en_n, clr_n);
      chk("t3_done_cyc", dc, 6 * (p + 1));
      chk("t3_en_cnt",   en_n, 3);
      chk("t3_clr_cnt",  clr_n, 1);
      chk("t3_cntq",     cnt_a, 3);
      $display("T3 period %0d: done_cycle=%0d en=%0d", p, dc, en_n);
      if (p < 3) begin
        step();
        chk("t3_laps", bus_a.laps, p + 1);
        c = dc + 1;
      end else begin
        bus_a.stop = 1'b1;
        step();
        bus_a.stop = 1'b0;
        chk("t3_stop_busy", bus_a.busy, 0);
        chk("t3_laps_fin",  bus_a.laps, 4);
        chk("t3_cntq_held", cnt_a, 3);
      end
    end

    // T4: tc=9, pause held high for cycles 6..8 while cnt_q=4.
    start_a(4'd9, 1'b0);
    step(); step(); step(); step(); step();       // cycle 6
    chk("t4_cntq_at_pause", cnt_a, 4);
    chk("t4_en_before",     bus_a.cnt_en, 1);
    bus_a.pause = 1'b1;
    #1;
    chk("t4_en_same_cyc",   bus_a.cnt_en, 0);
    step();                                       // cycle 7
    chk("t4_paused",        bus_a.paused, 1);
    chk("t4_cntq_held7",    cnt_a, 4);
    step();                                       // cycle 8
    chk("t4_cntq_held8",    cnt_a, 4);
    step();                                       // cycle 9, still HOLD
    bus_a.pause = 1'b0;
    #1;
    chk("t4_paused9",       bus_a.paused, 1);
    // HOLD->RUN costs one edge, so done lands four cycles after the unpaused cycle 12.
    run_until_done(9, 40, dc, en_n, clr_n);
    chk("t4_done_cyc",      dc, 16);
    chk("t4_en_cnt",        en_n, 5);
    chk("t4_cntq",          cnt_a, 9);
    step();
    $display("T4 pause: done_cycle=%0d cnt_q=%0d", dc, cnt_a);

    // T5a: tc=0 means done in cycle 3 with no enable.
    start_a(4'd0, 1'b0);
    run_until_done(1, 20, dc, en_n, clr_n);
    chk("t5_tc0_done", dc, 3);
    chk("t5_tc0_en",   en_n, 0);
    step();
    $display("T5 tc=0: done_cycle=%0d en=%0d", dc, en_n);

    // T5b: tc=15 means the counter stops at all-ones and does not wrap.
    start_a(4'd15, 1'b0);
    run_until_done(1, 40, dc, en_n, clr_n);
    chk("t5_tc15_done", dc, 18);
    chk("t5_tc15_en",   en_n, 15);
    step(); step();
    chk("t5_tc15_cntq", cnt_a, 15);
    chk("t5_tc15_busy", bus_a.busy, 0);
    $display("T5 tc=15: done_cycle=%0d cnt_q=%0d", dc, cnt_a);

    // T5c: a start while busy, with new tc/mode, is ignored.
    start_a(4'd5, 1'b0);
    step(); step();                               // cycle 3
    bus_a.tc = 4'd2; bus_a.mode = 1'b1; bus_a.start = 1'b1;
    step();                                       // cycle 4
    bus_a.start = 1'b0; bus_a.tc = 4'd0; bus_a.mode = 1'b0;
    run_until_done(4, 40, dc, en_n, clr_n);
    chk("t5_busy_start_done", dc, 8);
    chk("t5_busy_start_cntq", cnt_a, 5);
    step();
    chk("t5_busy_start_idle", bus_a.busy, 0);
    chk("t5_busy_start_laps", bus_a.laps, 1);
    $display("T5 start while busy: done_cycle=%0d laps=%0d", dc, bus_a.laps);

    // T5d: stop and pause together in RUN abort the run. stop has priority.
    start_a(4'd9, 1'b0);
    step(); step(); step();                       // cycle 4, cnt_q = 2
    bus_a.stop = 1'b1; bus_a.pause = 1'b1;
    #1;
    chk("t5_sp_en", bus_a.cnt_en, 0);
    step();
    bus_a.stop = 1'b0; bus_a.pause = 1'b0;
    chk("t5_sp_busy",   bus_a.busy, 0);
    chk("t5_sp_paused", bus_a.paused, 0);
    chk("t5_sp_cntq",   cnt_a, 2);
    $display("T5 stop+pause: busy=%0d cnt_q=%0d", bus_a.busy, cnt_a);

    // T6: a 2-bit lap counter saturates at 3 (tc=1, auto-reload).
    lap_exp[0] = 2'd1; lap_exp[1] = 2'd2; lap_exp[2] = 2'd3;
    lap_exp[3] = 2'd3; lap_exp[4] = 2'd3;
    bus_b.tc = 4'd1; bus_b.mode = 1'b1; bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int p = 0; p < 5; p++) begin
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        if (bus_b.done) found = 1;
        else step();
      end
      chk("t6_done_seen", found, 1);
      step();
      chk("t6_laps", bus_b.laps, lap_exp[p]);
      $display("T6 period %0d: laps=%0d", p, bus_b.laps);
    end
    bus_b.stop = 1'b1;
    step(); step();
    bus_b.stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
